// File: rtl/hamming_scrubber_if.sv
// rtl/hamming_scrubber_if.sv - scrubber-to-RAM port bundle
//
// Purpose: groups the single RAM port the scrubber drives.
//   mem_addr       word address (scrubber -> RAM)
//   mem_rd_enable  read strobe; data returns the following cycle
//   mem_wr_enable  write strobe; never high with mem_rd_enable
//   mem_wr_data    codeword to write
//   mem_rd_data    codeword read back (RAM -> scrubber)
// Modports: master = scrubber side, slave = RAM side.

interface hamming_scrubber_if #(
    parameter int addr_w = 4
);
    logic [addr_w-1:0] mem_addr;
    logic              mem_rd_enable;
    logic              mem_wr_enable;
    logic [11:0]       mem_wr_data;
    logic [11:0]       mem_rd_data;

    modport master (
        output mem_addr,
        output mem_rd_enable,
        output mem_wr_enable,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_enable,
        input  mem_wr_enable,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/hamming_scrubber.sv
// rtl/hamming_scrubber.sv - background Hamming(12,8) RAM scrubber
//
// Purpose: sweeps RAM addresses 0..num_words-1, checks each codeword,
// writes single-bit corrections back in place and counts/flags errors.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   scrub_en       keep sweeping while high; low stops after current word
//   cnt_clr        synchronous clear of both error counters
//   mem            RAM port (master side of hamming_scrubber_if)
//   busy           high whenever the FSM is not idle
//   sweep_done     one-cycle pulse after the last word of a sweep
//   err_flag       one-cycle pulse on a corrected or uncorrectable word
//   err_uncorr     qualifies err_flag: 1 = uncorrectable
//   err_addr       address of the most recent error
//   corr_count     saturating count of corrected words
//   uncorr_count   saturating count of uncorrectable words

module hamming_scrubber #(
    parameter int num_words = 4,
    parameter int addr_w    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scrub_en,
    input  logic               cnt_clr,
    hamming_scrubber_if.master mem,
    output logic               busy,
    output logic               sweep_done,
    output logic               err_flag,
    output logic               err_uncorr,
    output logic [addr_w-1:0]  err_addr,
    output logic [15:0]        corr_count,
    output logic [15:0]        uncorr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CHK  = 2'd2,
        WR   = 2'd3
    } state_t;

    localparam logic [addr_w-1:0] last_addr = addr_w'(num_words - 1);

    // Bit i holds Hamming position i+1; mask k selects the positions whose
    // index has bit k set.
    localparam logic [11:0] syn_mask0 = 12'h555;
    localparam logic [11:0] syn_mask1 = 12'h666;
    localparam logic [11:0] syn_mask2 = 12'h878;
    localparam logic [11:0] syn_mask3 = 12'hF80;

    state_t            state_q;
    state_t            state_d;
    logic [addr_w-1:0] addr_q;
    logic [11:0]       wr_data_q;
    logic              sweep_done_q;
    logic              err_flag_q;
    logic              err_uncorr_q;
    logic [addr_w-1:0] err_addr_q;
    logic [15:0]       corr_q;
    logic [15:0]       uncorr_q;

    logic [3:0]        syndrome;
    logic              correctable;
    logic              uncorrectable;
    logic [11:0]       corrected;
    logic              word_end;
    logic              in_chk;

    // Syndrome of the word on mem_rd_data; only meaningful during CHK.
    always_comb begin
        syndrome[0] = ^(mem.mem_rd_data & syn_mask0);
        syndrome[1] = ^(mem.mem_rd_data & syn_mask1);
        syndrome[2] = ^(mem.mem_rd_data & syn_mask2);
        syndrome[3] = ^(mem.mem_rd_data & syn_mask3);
    end

    assign correctable   = (syndrome != 4'd0) && (syndrome <= 4'd12);
    assign uncorrectable = (syndrome >= 4'd13);
    assign corrected     = correctable ? (mem.mem_rd_data ^ (12'd1 << (syndrome - 4'd1)))
                                       : mem.mem_rd_data;
    assign in_chk        = (state_q == CHK);

    // A word finishes either in CHK when no write-back is needed, or in WR.
    assign word_end = (in_chk && !correctable) || (state_q == WR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = scrub_en ? RD : IDLE;
            RD:   state_d = CHK;
            CHK: begin
                if (correctable) begin
                    state_d = WR;
                end else begin
                    state_d = scrub_en ? RD : IDLE;
                end
            end
            WR:   state_d = scrub_en ? RD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: strobes decoded from the registered state, the rest straight
    // from registers, so nothing here can glitch.
    always_comb begin
        mem.mem_rd_enable = (state_q == RD);
        mem.mem_wr_enable = (state_q == WR);
        mem.mem_addr      = addr_q;
        mem.mem_wr_data   = wr_data_q;
        busy              = (state_q != IDLE);
        sweep_done        = sweep_done_q;
        err_flag          = err_flag_q;
        err_uncorr        = err_uncorr_q;
        err_addr          = err_addr_q;
        corr_count        = corr_q;
        uncorr_count      = uncorr_q;
    end

    // Address, write-back data and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wr_data_q    <= '0;
            sweep_done_q <= 1'b0;
            err_flag_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            sweep_done_q <= 1'b0;
            err_flag_q   <= 1'b0;
            err_uncorr_q <= 1'b0;

            if (word_end) begin
                if (addr_q == last_addr) begin
                    addr_q       <= '0;
                    sweep_done_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + addr_w'(1);
                end
            end

            if (in_chk) begin
                if (correctable) begin
                    wr_data_q <= corrected;
                end
                if (syndrome != 4'd0) begin
                    err_flag_q   <= 1'b1;
                    err_uncorr_q <= uncorrectable;
                    err_addr_q   <= addr_q;
                end
            end
        end
    end

    // Saturating error counters; a same-cycle clear beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (cnt_clr) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            if (in_chk && correctable && (corr_q != 16'hFFFF)) begin
                corr_q <= corr_q + 16'd1;
            end
            if (in_chk && uncorrectable && (uncorr_q != 16'hFFFF)) begin
                uncorr_q <= uncorr_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_scrubber.sv
// tb/tb_hamming_scrubber.sv - directed self-checking bench for hamming_scrubber

module tb_hamming_scrubber;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scrub_en;
    logic        cnt_clr;
    logic        busy;
    logic        sweep_done;
    logic        err_flag;
    logic        err_uncorr;
    logic [3:0]  err_addr;
    logic [15:0] corr_count;
    logic [15:0] uncorr_count;

    hamming_scrubber_if #(.addr_w(4)) mem_if ();

    hamming_scrubber #(.num_words(4), .addr_w(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scrub_en     (scrub_en),
        .cnt_clr      (cnt_clr),
        .mem          (mem_if),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .err_flag     (err_flag),
        .err_uncorr   (err_uncorr),
        .err_addr     (err_addr),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, write on strobe, plus a bench load port.
    logic [11:0] ram [0:3];
    logic [11:0] rd_q = 12'h000;
    logic        ld_en = 1'b0;
    logic [1:0]  ld_addr = 2'd0;
    logic [11:0] ld_data = 12'h000;
    int          wr_cnt = 0;
    int          sd_cnt = 0;

    assign mem_if.mem_rd_data = rd_q;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_if.mem_wr_enable) begin
            ram[mem_if.mem_addr[1:0]] <= mem_if.mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_if.mem_rd_enable) begin
            rd_q <= ram[mem_if.mem_addr[1:0]];
        end
    end

    always @(posedge clk) begin
        if (sweep_done) sd_cnt <= sd_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [11:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int second;
        int wr0;
        int sd0;

        rst_n    = 1'b0;
        scrub_en = 1'b0;
        cnt_clr  = 1'b0;

        // Reset state, RAM image {FFF, 000, FFF, 000}
        load(2'd0, 12'hFFF);
        load(2'd1, 12'h000);
        load(2'd2, 12'hFFF);
        load(2'd3, 12'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_en", mem_if.mem_rd_enable, 1'b0);
        chk("rst_wr_en", mem_if.mem_wr_enable, 1'b0);
        chk("rst_addr", mem_if.mem_addr, 4'd0);
        chk("rst_flag", err_flag, 1'b0);
        chk("rst_sd", sweep_done, 1'b0);
        chk("rst_corr", corr_count, 16'd0);
        chk("rst_uncorr", uncorr_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Sweep 1: words 0 and 2 have syndrome 12 -> 0x7FF, 10 cycles
        wr0 = wr_cnt;
        sd0 = sd_cnt;
        first = 0;
        scrub_en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("s1_first_rd", mem_if.mem_rd_enable, 1'b1);
                chk("s1_first_addr", mem_if.mem_addr, 4'd0);
            end
            if (c == 3) chk("s1_wr0", mem_if.mem_wr_enable, 1'b1);
            if (sweep_done && first == 0) first = c;
            if (c == 10) scrub_en = 1'b0;
        end
        chk("s1_done_cycle", first, 11);
        chk("s1_done_pulses", sd_cnt - sd0, 1);
        chk("s1_writes", wr_cnt - wr0, 2);
        chk("s1_ram0", ram[0], 12'h7FF);
        chk("s1_ram1", ram[1], 12'h000);
        chk("s1_ram2", ram[2], 12'h7FF);
        chk("s1_corr", corr_count, 16'd2);
        chk("s1_uncorr", uncorr_count, 16'd0);
        chk("s1_err_addr", err_addr, 4'd2);
        chk("s1_idle", busy, 1'b0);
        chk("s1_addr_wrap", mem_if.mem_addr, 4'd0);

        // Clear counters, then two clean sweeps of an all-zero RAM
        load(2'd0, 12'h000);
        load(2'd2, 12'h000);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_corr", corr_count, 16'd0);
        wr0 = wr_cnt;
        sd0 = sd_cnt;
        first = 0;
        second = 0;
        scrub_en = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sweep_done) begin
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
            if (c == 16) scrub_en = 1'b0;
        end
        chk("s2_done1", first, 9);
        chk("s2_done2", second, 17);
        chk("s2_pulses", sd_cnt - sd0, 2);
        chk("s2_writes", wr_cnt - wr0, 0);
        chk("s2_corr", corr_count, 16'd0);
        chk("s2_uncorr", uncorr_count, 16'd0);

        // Word 1 = 0x001 (syndrome 1); scrub_en dropped during its CHK
        load(2'd1, 12'h001);
        wr0 = wr_cnt;
        scrub_en = 1'b1;
        repeat (4) @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
        chk("w1_wr_en", mem_if.mem_wr_enable, 1'b1);
        chk("w1_rd_en", mem_if.mem_rd_enable, 1'b0);
        chk("w1_wr_addr", mem_if.mem_addr, 4'd1);
        chk("w1_wr_data", mem_if.mem_wr_data, 12'h000);
        chk("w1_flag", err_flag, 1'b1);
        chk("w1_uncorr", err_uncorr, 1'b0);
        chk("w1_err_addr", err_addr, 4'd1);
        chk("w1_corr", corr_count, 16'd1);
        @(negedge clk);
        chk("w1_idle", busy, 1'b0);
        chk("w1_hold_addr", mem_if.mem_addr, 4'd2);
        chk("w1_flag_pulse", err_flag, 1'b0);
        chk("w1_ram", ram[1], 12'h000);
        chk("w1_writes", wr_cnt - wr0, 1);

        // Resume at address 2; word 3 = 0x801 (syndrome 13)
        load(2'd3, 12'h801);
        wr0 = wr_cnt;
        scrub_en = 1'b1;
        @(negedge clk);
        chk("w3_resume_addr", mem_if.mem_addr, 4'd2);
        chk("w3_resume_rd", mem_if.mem_rd_enable, 1'b1);
        repeat (3) @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
        chk("w3_flag", err_flag, 1'b1);
        chk("w3_uncorr", err_uncorr, 1'b1);
        chk("w3_err_addr", err_addr, 4'd3);
        chk("w3_uncorr_cnt", uncorr_count, 16'd1);
        chk("w3_sd", sweep_done, 1'b1);
        chk("w3_wr_en", mem_if.mem_wr_enable, 1'b0);
        chk("w3_idle", busy, 1'b0);
        @(negedge clk);
        chk("w3_sd_pulse", sweep_done, 1'b0);
        chk("w3_ram", ram[3], 12'h801);
        chk("w3_writes", wr_cnt - wr0, 0);

        // cnt_clr on the same edge as a correction at address 0
        load(2'd0, 12'h001);
        scrub_en = 1'b1;
        repeat (2) @(negedge clk);
        cnt_clr  = 1'b1;
        scrub_en = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_win_corr", corr_count, 16'd0);
        chk("clr_win_uncorr", uncorr_count, 16'd0);
        chk("clr_win_flag", err_flag, 1'b1);
        chk("clr_win_wr", mem_if.mem_wr_enable, 1'b1);
        @(negedge clk);
        chk("clr_win_ram", ram[0], 12'h000);
        chk("clr_win_addr", mem_if.mem_addr, 4'd1);

        // Saturation: preload corr_count to 0xFFFF, then correct word 1
        load(2'd1, 12'h001);
        dut.corr_q = 16'hFFFF;
        @(negedge clk);
        chk("sat_preload", corr_count, 16'hFFFF);
        scrub_en = 1'b1;
        repeat (2) @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
        chk("sat_flag", err_flag, 1'b1);
        chk("sat_corr", corr_count, 16'hFFFF);
        @(negedge clk);
        chk("sat_ram", ram[1], 12'h000);

        // Reset asserted in the middle of WR at address 2
        load(2'd2, 12'h001);
        wr0 = wr_cnt;
        scrub_en = 1'b1;
        repeat (2) @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
        chk("rwr_wr_en_before", mem_if.mem_wr_enable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rwr_wr_en", mem_if.mem_wr_enable, 1'b0);
        chk("rwr_rd_en", mem_if.mem_rd_enable, 1'b0);
        chk("rwr_busy", busy, 1'b0);
        chk("rwr_addr", mem_if.mem_addr, 4'd0);
        chk("rwr_wr_data", mem_if.mem_wr_data, 12'h000);
        chk("rwr_flag", err_flag, 1'b0);
        chk("rwr_uncorr", err_uncorr, 1'b0);
        chk("rwr_err_addr", err_addr, 4'd0);
        chk("rwr_corr", corr_count, 16'd0);
        chk("rwr_uncorr_cnt", uncorr_count, 16'd0);
        chk("rwr_sd", sweep_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rwr_no_reissue", wr_cnt - wr0, 0);
        chk("rwr_ram", ram[2], 12'h001);
        chk("rwr_still_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
